// File: rtl/neuron_mac_seq_if.sv
// Handshake bundle for the serial neuron: input vector, weight-bank
// write port and result stream.
interface neuron_mac_seq_if #(
    parameter int N_IN = 5,
    parameter int DW   = 8,
    parameter int WW   = 8
);
    localparam int AW = $clog2(N_IN + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*DW-1:0]   in_data;
    logic                 w_wr_en;
    logic [AW-1:0]        w_wr_addr;
    logic [DW+WW-1:0]     w_wr_data;
    logic                 w_wr_err;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic                 sat_flag;

    modport master (
        output in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, out_ready,
        input  in_ready, w_wr_err, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, out_ready,
        output in_ready, w_wr_err, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one signed MAC walks N_IN activations, then
// shift, optional ReLU and saturation produce the output word.
module neuron_mac_seq #(
    parameter int N_IN  = 5,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int SHIFT = 6,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             reset,
    neuron_mac_seq_if.slave  bus
);
    localparam int AW    = $clog2(N_IN + 1);
    localparam int ACC_W = DW + WW + AW;

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]    x    [N_IN];
    logic signed [WW-1:0]    w    [N_IN];
    logic signed [WW-1:0]    wl   [N_IN];
    logic signed [ACC_W-1:0] bias;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] xs;
    logic signed [ACC_W-1:0] ws;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] r;
    logic [AW-1:0]           idx;
    logic                    last;
    logic                    wr_ok;
    logic                    wr_bad;
    logic [DW-1:0]           res;
    logic                    res_sat;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic                    sat_flag;
    logic                    w_wr_err;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.sat_flag  = sat_flag;
    assign bus.w_wr_err  = w_wr_err;

    assign last   = (idx == AW'(N_IN - 1));
    assign wr_ok  = bus.w_wr_en && (state == IDLE) &&
                    (bus.w_wr_addr <= AW'(N_IN));
    assign wr_bad = bus.w_wr_en && !wr_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_nx = MAC;
            MAC:  if (last)          state_nx = POST;
            POST:                    state_nx = OUT;
            OUT:  if (bus.out_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        xs   = {{(ACC_W-DW){x[idx][DW-1]}}, x[idx]};
        ws   = {{(ACC_W-WW){wl[idx][WW-1]}}, wl[idx]};
        prod = xs * ws;
    end

    // Arithmetic shift floors toward -inf; ReLU wins over clamping.
    always_comb begin
        r       = acc >>> SHIFT;
        res     = r[DW-1:0];
        res_sat = 1'b0;
        if (RELU != 0 && r[ACC_W-1]) begin
            res = '0;
        end else if (r > MAXV) begin
            res     = MAXV[DW-1:0];
            res_sat = 1'b1;
        end else if (r < MINV) begin
            res     = MINV[DW-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                x[i]  <= '0;
                w[i]  <= '0;
                wl[i] <= '0;
            end
            bias      <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
            w_wr_err  <= 1'b0;
        end else begin
            w_wr_err <= wr_bad;
            if (wr_ok) begin
                if (bus.w_wr_addr == AW'(N_IN))
                    bias <= {{(ACC_W-DW-WW){bus.w_wr_data[DW+WW-1]}},
                             bus.w_wr_data};
                else
                    w[bus.w_wr_addr] <= bus.w_wr_data[WW-1:0];
            end
            unique case (state)
                IDLE: begin
                    // Snapshot the bank so a same-cycle write cannot leak in.
                    if (bus.in_valid) begin
                        for (int i = 0; i < N_IN; i++) begin
                            x[i]  <= bus.in_data[i*DW +: DW];
                            wl[i] <= w[i];
                        end
                        acc <= bias;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    idx <= last ? '0 : idx + 1'b1;
                end
                POST: begin
                    out_valid <= 1'b1;
                    out_data  <= res;
                    sat_flag  <= res_sat;
                end
                OUT: begin
                    if (bus.out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: ReLU and signed variants side by side,
// expected results queued at accept time and checked at output.
module tb_neuron_mac_seq;
    localparam int N     = 5;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int SHIFT = 6;

    typedef struct {
        int o1;
        int s1;
        int o0;
        int s0;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    neuron_mac_seq_if #(.N_IN(N), .DW(DW), .WW(WW)) b1 ();
    neuron_mac_seq_if #(.N_IN(N), .DW(DW), .WW(WW)) b0 ();

    assign b0.in_valid  = b1.in_valid;
    assign b0.in_data   = b1.in_data;
    assign b0.w_wr_en   = b1.w_wr_en;
    assign b0.w_wr_addr = b1.w_wr_addr;
    assign b0.w_wr_data = b1.w_wr_data;
    assign b0.out_ready = b1.out_ready;

    neuron_mac_seq #(.N_IN(N), .DW(DW), .WW(WW), .SHIFT(SHIFT), .RELU(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    neuron_mac_seq #(.N_IN(N), .DW(DW), .WW(WW), .SHIFT(SHIFT), .RELU(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc;
    int   mw [N];
    int   mb;
    exp_t sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int x[N]);
        longint a;
        longint r;
        exp_t   e;
        a = mb;
        for (int i = 0; i < N; i++) a += longint'(x[i]) * mw[i];
        r = a >>> SHIFT;
        if (r > 127) begin
            e.o0 = 127;  e.s0 = 1;
        end else if (r < -128) begin
            e.o0 = -128; e.s0 = 1;
        end else begin
            e.o0 = int'(r); e.s0 = 0;
        end
        if (r < 0) begin
            e.o1 = 0; e.s1 = 0;
        end else begin
            e.o1 = e.o0; e.s1 = e.s0;
        end
        return e;
    endfunction

    task automatic bank_update(input int a, input int d);
        logic signed [7:0]  w8;
        logic signed [15:0] b16;
        w8  = d[7:0];
        b16 = d[15:0];
        if (a == N) mb = b16;
        else        mw[a] = w8;
    endtask

    task automatic wr(input int a, input int d, input bit ok);
        @(negedge clk);
        b1.w_wr_en   = 1'b1;
        b1.w_wr_addr = a[2:0];
        b1.w_wr_data = d[15:0];
        @(negedge clk);
        b1.w_wr_en = 1'b0;
        chk("wr_err", int'(b1.w_wr_err), ok ? 0 : 1);
        if (ok) bank_update(a, d);
        @(negedge clk);
        chk("wr_err_pulse", int'(b1.w_wr_err), 0);
    endtask

    task automatic send(input int x[N], input bit push,
                        input bit w, input int wa, input int wd);
        int k = 0;
        @(negedge clk);
        while (!b1.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", int'(b1.in_ready), 1);
        for (int i = 0; i < N; i++) b1.in_data[i*DW +: DW] = x[i][7:0];
        b1.in_valid = 1'b1;
        if (w) begin
            b1.w_wr_en   = 1'b1;
            b1.w_wr_addr = wa[2:0];
            b1.w_wr_data = wd[15:0];
        end
        if (push) sb.push_back(model(x));
        if (w) bank_update(wa, wd);
        @(negedge clk);
        acc_cyc     = cyc;
        b1.in_valid = 1'b0;
        b1.w_wr_en  = 1'b0;
        b1.in_data  = {$urandom, $urandom};
        if (w) chk("wr_err_idle", int'(b1.w_wr_err), 0);
    endtask

    task automatic collect(input bit hold);
        int   k = 0;
        exp_t e;
        while (!b1.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid", int'(b1.out_valid), 1);
        chk("out_valid0", int'(b0.out_valid), 1);
        chk("latency", cyc - acc_cyc, N + 1);
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk("out_data", int'($signed(b1.out_data)), e.o1);
        chk("sat_flag", int'(b1.sat_flag), e.s1);
        chk("out_data0", int'($signed(b0.out_data)), e.o0);
        chk("sat_flag0", int'(b0.sat_flag), e.s0);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", int'(b1.out_valid), 1);
                chk("hold_data", int'($signed(b1.out_data)), e.o1);
                chk("hold_sat", int'(b1.sat_flag), e.s1);
                chk("hold_in_ready", int'(b1.in_ready), 0);
            end
            b1.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("out_valid_drop", int'(b1.out_valid), 0);
        chk("in_ready_back", int'(b1.in_ready), 1);
    endtask

    initial begin
        int v10 [N];
        int v127[N];
        int vm  [N];
        int v1  [N];
        int wp  [N];
        int wn  [N];
        v10  = '{10, 10, 10, 10, 10};
        v127 = '{127, 127, 127, 127, 127};
        vm   = '{-128, -128, -128, -128, -128};
        v1   = '{1, 1, 1, 1, 1};
        wp   = '{10, 20, 30, 40, 50};
        wn   = '{-14, -48, -57, -70, -1};
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb = 0;

        reset        = 1'b0;
        b1.in_valid  = 1'b0;
        b1.in_data   = '0;
        b1.w_wr_en   = 1'b0;
        b1.w_wr_addr = '0;
        b1.w_wr_data = '0;
        b1.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", int'(b1.in_ready), 1);
        chk("rst_out_valid", int'(b1.out_valid), 0);
        chk("rst_out_data", int'(b1.out_data), 0);
        chk("rst_sat", int'(b1.sat_flag), 0);
        chk("rst_wr_err", int'(b1.w_wr_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < N; i++) wr(i, wp[i], 1'b1);
        wr(N, 0, 1'b1);
        send(v10, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        wr(N, 100, 1'b1);
        send(v10, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        for (int i = 0; i < N; i++) wr(i, wn[i], 1'b1);
        wr(N, 0, 1'b1);
        send(v10, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        for (int i = 0; i < N; i++) wr(i, 127, 1'b1);
        b1.out_ready = 1'b0;
        send(v127, 1'b1, 1'b0, 0, 0);
        collect(1'b1);

        send(vm, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        send(v10, 1'b1, 1'b0, 0, 0);
        wr(0, 5, 1'b0);
        collect(1'b0);

        wr(6, 1, 1'b0);

        send(v1, 1'b1, 1'b1, N, 6400);
        collect(1'b0);
        send(v1, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        send(v10, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_valid", int'(b1.out_valid), 0);
            chk("abort_in_ready", int'(b1.in_ready), 1);
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb = 0;
        repeat (N + 3) begin
            @(negedge clk);
            chk("abort_no_result", int'(b1.out_valid), 0);
        end
        send(v10, 1'b1, 1'b0, 0, 0);
        collect(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
